// File: rtl/clk_ctrl_pkg.sv
// Shared types for the core clock-enable controller.
// Mode encodings, debounce state enum and a mode helper.
package clk_ctrl_pkg;

  localparam logic [1:0] MODE_NORM = 2'b00;
  localparam logic [1:0] MODE_DBG  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_REL_WAIT
  } db_state_e;

  function automatic logic mode_runs(
    input logic [1:0] m
  );
    return (m == MODE_NORM) || (m == MODE_DBG);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchroniser, 4-state FSM, stability counter.
// Ports: CLOCK_50, reset_n, key_n (raw, active-low) -> key_db (level), press_pulse (1 cycle).
module key_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_n,
  output logic key_db,
  output logic press_pulse
);

  localparam int DEB_W =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST =
    DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             pressed;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;
  logic             key_db_d;
  logic             pulse_d;

  // Synchroniser resets to the released level so reset never
  // looks like a press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign pressed = ~sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_db_d = key_db;
    pulse_d  = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (pressed) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = DB_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = DB_PRESSED;
          key_db_d = 1'b1;
          pulse_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!pressed) begin
          state_d = DB_REL_WAIT;
          cnt_d   = '0;
        end
      end
      DB_REL_WAIT: begin
        if (pressed) begin
          state_d = DB_PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = DB_IDLE;
          key_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DB_IDLE;
      cnt_q       <= '0;
      key_db      <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_db      <= key_db_d;
      press_pulse <= pulse_d;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Core clock-enable generator: normal/debug divide, single-step, halt.
// Ports: CLOCK_50, reset_n, mode, step_key -> cpu_ce, ce_vis, ce_count, key_db, LEDR.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int NORM_DIV   = 64,
  parameter int DBG_DIV    = 33554432,
  parameter int DIV_W      = 28,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 16,
  parameter int LED_W      = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             step_key,
  output logic             cpu_ce,
  output logic             ce_vis,
  output logic [CNT_W-1:0] ce_count,
  output logic             key_db,
  output logic [LED_W-1:0] LEDR
);

  localparam logic [DIV_W-1:0] NORM_LAST =
    DIV_W'(NORM_DIV - 1);
  localparam logic [DIV_W-1:0] DBG_LAST =
    DIV_W'(DBG_DIV - 1);

  logic [1:0]       mode_meta_q;
  logic [1:0]       mode_s;
  logic [1:0]       mode_prev;
  logic             mode_chg;
  logic             key_press;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] div_last;
  logic             ce_d;
  logic [CNT_W-1:0] cnt_d;
  logic             vis_d;
  logic [LED_W-1:0] led_d;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .key_n       (step_key),
    .key_db      (key_db),
    .press_pulse (key_press)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mode_meta_q <= MODE_NORM;
      mode_s      <= MODE_NORM;
      mode_prev   <= MODE_NORM;
    end else begin
      mode_meta_q <= mode;
      mode_s      <= mode_meta_q;
      mode_prev   <= mode_s;
    end
  end

  // A new synchronised mode restarts the divider and drops any
  // enable (including a step press) in the cycle it is seen.
  assign mode_chg = (mode_s != mode_prev);

  always_comb begin
    div_d    = '0;
    ce_d     = 1'b0;
    div_last = (mode_s == MODE_DBG) ? DBG_LAST : NORM_LAST;
    if (!mode_chg) begin
      unique case (1'b1)
        mode_runs(mode_s): begin
          if (div_q == div_last) begin
            ce_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        (mode_s == MODE_STEP): begin
          ce_d = key_press;
        end
        default: begin
          ce_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = ce_d ? ce_count + CNT_W'(1) : ce_count;
    vis_d = ce_vis ^ ce_d;
    // LED_W <= DIV_W and LED_W <= CNT_W are assumed.
    if (mode_runs(mode_s)) begin
      led_d = div_d[DIV_W-1 -: LED_W];
    end else begin
      led_d = cnt_d[LED_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      cpu_ce   <= 1'b0;
      ce_count <= '0;
      ce_vis   <= 1'b0;
      LEDR     <= '0;
    end else begin
      div_q    <= div_d;
      cpu_ce   <= ce_d;
      ce_count <= cnt_d;
      ce_vis   <= vis_d;
      LEDR     <= led_d;
    end
  end

endmodule
